// File: rtl/note_player_if.sv
`default_nettype none
// ============================================================================
// Module : note_player_if
// Brief  : Sequencer/ROM-side signal bundle for note_player.
// Rev    : 1.0  initial release
// ============================================================================
interface note_player_if #(
    parameter int BEAT_W = 6
);
    logic              play;
    logic              new_note;
    logic [5:0]        note;
    logic [BEAT_W-1:0] duration;
    logic              beat;
    logic [15:0]       half_period;
    logic              note_done;
    logic              load_new_note;
    logic [5:0]        cur_note;
    logic              busy;
    logic              tone;

    modport master (
        output play, new_note, note, duration, beat, half_period,
        input  note_done, load_new_note, cur_note, busy, tone
    );

    modport slave (
        input  play, new_note, note, duration, beat, half_period,
        output note_done, load_new_note, cur_note, busy, tone
    );
endinterface
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module : note_player
// Brief  : Plays one note at a time: beat-counted duration, square-wave tone.
// Rev    : 1.0  initial release
// ============================================================================
module note_player #(
    parameter int BEAT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    note_player_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAITROM = 3'd2,
        PLAYING = 3'd3,
        PAUSED  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] remain;
    logic [15:0]       hp_reg;
    logic [15:0]       div_cnt;
    logic [5:0]        cur_note;
    logic              note_done;
    logic              tone;

    logic              last_beat;
    logic              tone_en;

    assign last_beat = bus.beat && (remain == BEAT_W'(1));
    assign tone_en   = (cur_note != 6'd0) && (hp_reg != 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remain    <= '0;
            hp_reg    <= 16'd0;
            div_cnt   <= 16'd0;
            cur_note  <= 6'd0;
            note_done <= 1'b0;
            tone      <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.new_note) begin
                        cur_note <= bus.note;
                        remain   <= bus.duration;
                        if (bus.duration == '0) begin
                            note_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: state <= WAITROM;
                WAITROM: begin
                    hp_reg  <= bus.half_period;
                    div_cnt <= 16'd0;
                    tone    <= 1'b0;
                    state   <= PLAYING;
                end
                PLAYING: begin
                    // Pause wins over a coincident beat, so no decrement here.
                    if (!bus.play) begin
                        state <= PAUSED;
                    end else if (last_beat) begin
                        remain    <= remain - BEAT_W'(1);
                        tone      <= 1'b0;
                        div_cnt   <= 16'd0;
                        note_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (bus.beat) begin
                            remain <= remain - BEAT_W'(1);
                        end
                        if (!tone_en) begin
                            tone    <= 1'b0;
                            div_cnt <= 16'd0;
                        end else if (div_cnt == hp_reg - 16'd1) begin
                            tone    <= ~tone;
                            div_cnt <= 16'd0;
                        end else begin
                            div_cnt <= div_cnt + 16'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.play) begin
                        state <= PLAYING;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cur_note      = cur_note;
    assign bus.note_done     = note_done;
    assign bus.tone          = tone;
    assign bus.busy          = (state != IDLE);
    assign bus.load_new_note = (state == LOAD);
endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
// Module : tb_note_player
// Brief  : Directed and randomized checks of note_player against a beat/tone model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_note_player;
    localparam int BEAT_W = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    note_player_if #(.BEAT_W(BEAT_W)) bus ();
    note_player #(.BEAT_W(BEAT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model: beats left, pause flag, and number of cycles the tone has advanced.
    int m_left, m_active, m_hp;
    bit m_paused, m_en, m_fin;

    function automatic void model_start(input int n, input int d, input int hp);
        m_left = d; m_active = 0; m_hp = hp; m_paused = 0; m_fin = 0;
        m_en = (n != 0) && (hp != 0);
    endfunction

    function automatic void model_edge(input bit p, input bit b);
        m_fin = 0;
        if (m_paused) begin
            if (p) m_paused = 0;
        end else if (!p) begin
            m_paused = 1;
        end else begin
            if (b) m_left--;
            if (m_left == 0) m_fin = 1;
            else m_active++;
        end
    endfunction

    function automatic bit model_tone();
        if (!m_en || m_fin) return 1'b0;
        return ((m_active / m_hp) % 2) == 1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_note(input int n, input int d, input int hp);
        bus.note = 6'(n); bus.duration = BEAT_W'(d); bus.half_period = 16'(hp);
        bus.beat = 1'b0; bus.new_note = 1'b1;
        step();
        bus.new_note = 1'b0;
    endtask

    task automatic test_reset();
        bus.play = 1'b1; bus.new_note = 1'b0; bus.note = '0; bus.duration = '0;
        bus.beat = 1'b0; bus.half_period = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        total++; if ({bus.tone, bus.note_done, bus.load_new_note, bus.busy} !== 4'b0) begin
            bad++; $display("FAIL reset_outs: got %b want 0000", {bus.tone, bus.note_done, bus.load_new_note, bus.busy}); end
        total++; if (bus.cur_note !== 6'd0) begin bad++; $display("FAIL reset_cur_note: got %0d want 0", bus.cur_note); end
        total++; if (dut.remain !== '0 || dut.hp_reg !== 16'd0 || dut.div_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_regs: remain=%0d hp=%0d cnt=%0d want 0", dut.remain, dut.hp_reg, dut.div_cnt); end
        @(negedge clk);
        reset = 1'b1; bus.note = 6'd7; bus.duration = '0; bus.new_note = 1'b1;
        @(posedge clk); #1;
        bus.new_note = 1'b0;
        total++; if (bus.cur_note !== 6'd7) begin bad++; $display("FAIL first_edge_accept: got %0d want 7", bus.cur_note); end
        total++; if (bus.note_done !== 1'b1) begin bad++; $display("FAIL first_edge_done: got %0b want 1", bus.note_done); end
        step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL first_edge_idle: busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        int cyc = 0, beats = 0, last_rise = -1;
        bit prev = 1'b0;
        bus.play = 1'b1;
        start_note(5, 3, 4);
        total++; if (bus.load_new_note !== 1'b1) begin bad++; $display("FAIL basic_load: got %0b want 1", bus.load_new_note); end
        total++; if (bus.cur_note !== 6'd5 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL basic_latch: cur_note=%0d busy=%0b want 5/1", bus.cur_note, bus.busy); end
        step();
        total++; if (bus.load_new_note !== 1'b0) begin bad++; $display("FAIL basic_load_width: got %0b want 0", bus.load_new_note); end
        step();
        model_start(5, 3, 4);
        while (!m_fin && cyc < 200) begin
            bus.beat = (cyc % 20 == 19);
            if (bus.beat) beats++;
            step(); cyc++;
            model_edge(1'b1, bus.beat);
            total++; if (bus.tone !== model_tone()) begin bad++; $display("FAIL basic_tone@%0d: got %0b want %0b", cyc, bus.tone, model_tone()); end
            total++; if (bus.note_done !== m_fin) begin bad++; $display("FAIL basic_done@%0d: got %0b want %0b", cyc, bus.note_done, m_fin); end
            total++; if (dut.remain !== BEAT_W'(m_left)) begin bad++; $display("FAIL basic_remain@%0d: got %0d want %0d", cyc, dut.remain, m_left); end
            if (bus.tone && !prev) begin
                if (last_rise >= 0) begin
                    total++; if (cyc - last_rise != 8) begin bad++; $display("FAIL basic_period: got %0d want 8", cyc - last_rise); end
                end
                last_rise = cyc;
            end
            prev = bus.tone;
            if (bus.note_done) begin
                total++; if (beats != 3) begin bad++; $display("FAIL basic_done_beat: got %0d beats want 3", beats); end
            end
        end
        bus.beat = 1'b0;
        total++; if (!m_fin) begin bad++; $display("FAIL basic_timeout: got %0d cycles want done", cyc); end
        step();
        total++; if (bus.busy !== 1'b0 || bus.note_done !== 1'b0) begin
            bad++; $display("FAIL basic_after: busy=%0b done=%0b want 0/0", bus.busy, bus.note_done); end
    endtask

    task automatic test_zero_duration();
        bus.play = 1'b1;
        start_note(9, 0, 4);
        total++; if (bus.note_done !== 1'b1 || bus.load_new_note !== 1'b0 || bus.tone !== 1'b0) begin
            bad++; $display("FAIL zero_dur: done=%0b load=%0b tone=%0b want 1/0/0", bus.note_done, bus.load_new_note, bus.tone); end
        step();
        total++; if (bus.note_done !== 1'b0 || bus.load_new_note !== 1'b0 || bus.busy !== 1'b0 || bus.tone !== 1'b0) begin
            bad++; $display("FAIL zero_dur_after: done=%0b load=%0b busy=%0b tone=%0b want 0", bus.note_done, bus.load_new_note, bus.busy, bus.tone); end
    endtask

    task automatic test_rest();
        int cyc = 0, beats = 0;
        bus.play = 1'b1;
        start_note(0, 2, 3);
        step(); step();
        model_start(0, 2, 3);
        while (!m_fin && cyc < 100) begin
            bus.beat = (cyc % 7 == 6);
            if (bus.beat) beats++;
            step(); cyc++;
            model_edge(1'b1, bus.beat);
            total++; if (bus.tone !== 1'b0) begin bad++; $display("FAIL rest_tone@%0d: got %0b want 0", cyc, bus.tone); end
            total++; if (bus.note_done !== m_fin) begin bad++; $display("FAIL rest_done@%0d: got %0b want %0b", cyc, bus.note_done, m_fin); end
            if (bus.note_done) begin
                total++; if (beats != 2) begin bad++; $display("FAIL rest_beats: got %0d want 2", beats); end
            end
        end
        bus.beat = 1'b0;
        total++; if (!m_fin) begin bad++; $display("FAIL rest_timeout: got %0d cycles want done", cyc); end
        step();
    endtask

    task automatic test_pause();
        int cyc = 0, b1 = -1, post = 0;
        bit frozen = 1'b0;
        start_note(12, 3, 5);
        step(); step();
        model_start(12, 3, 5);
        while (!m_fin && cyc < 400) begin
            bus.play = !(b1 >= 0 && cyc > b1 && cyc <= b1 + 50);
            bus.beat = (cyc % 10 == 9);
            if (bus.beat && b1 >= 0 && cyc > b1 + 50) post++;
            step();
            model_edge(bus.play, bus.beat);
            total++; if (bus.tone !== model_tone()) begin bad++; $display("FAIL pause_tone@%0d: got %0b want %0b", cyc, bus.tone, model_tone()); end
            total++; if (bus.note_done !== m_fin) begin bad++; $display("FAIL pause_done@%0d: got %0b want %0b", cyc, bus.note_done, m_fin); end
            if (!bus.play) begin
                total++; if (bus.tone !== frozen || dut.remain !== BEAT_W'(2)) begin
                    bad++; $display("FAIL pause_frozen@%0d: tone=%0b remain=%0d want %0b/2", cyc, bus.tone, dut.remain, frozen); end
            end
            if (b1 < 0 && m_left == 2) begin b1 = cyc; frozen = bus.tone; end
            if (bus.note_done) begin
                total++; if (post != 2) begin bad++; $display("FAIL pause_further_beats: got %0d want 2", post); end
            end
            cyc++;
        end
        bus.beat = 1'b0; bus.play = 1'b1;
        total++; if (!m_fin) begin bad++; $display("FAIL pause_timeout: got %0d cycles want done", cyc); end
        step();
    endtask

    task automatic test_pause_with_beat();
        int cyc = 0;
        bus.play = 1'b1;
        start_note(3, 4, 2);
        step(); step();
        model_start(3, 4, 2);
        repeat (5) begin step(); model_edge(1'b1, 1'b0); end
        bus.play = 1'b0; bus.beat = 1'b1;
        step();
        model_edge(1'b0, 1'b1);
        bus.beat = 1'b0;
        total++; if (dut.remain !== BEAT_W'(4)) begin bad++; $display("FAIL pause_beat_remain: got %0d want 4", dut.remain); end
        total++; if (bus.tone !== model_tone()) begin bad++; $display("FAIL pause_beat_tone: got %0b want %0b", bus.tone, model_tone()); end
        bus.play = 1'b1;
        while (!m_fin && cyc < 100) begin
            bus.beat = (cyc % 4 == 3);
            step(); cyc++;
            model_edge(1'b1, bus.beat);
            total++; if (dut.remain !== BEAT_W'(m_left) || bus.note_done !== m_fin) begin
                bad++; $display("FAIL pause_beat_resume@%0d: remain=%0d done=%0b want %0d/%0b", cyc, dut.remain, bus.note_done, m_left, m_fin); end
        end
        bus.beat = 1'b0;
        total++; if (!m_fin) begin bad++; $display("FAIL pause_beat_timeout: got %0d cycles want done", cyc); end
        step();
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        bus.play = 1'b1;
        start_note(21, 5, 2);
        step(); step();
        repeat (3) step();
        #3 reset = 1'b0;
        #1;
        total++; if ({bus.tone, bus.note_done, bus.load_new_note, bus.busy} !== 4'b0 || bus.cur_note !== 6'd0) begin
            bad++; $display("FAIL async_reset_outs: tone/done/load/busy=%b cur=%0d want 0", {bus.tone, bus.note_done, bus.load_new_note, bus.busy}, bus.cur_note); end
        total++; if (dut.remain !== '0) begin bad++; $display("FAIL async_reset_remain: got %0d want 0", dut.remain); end
        step();
        total++; if (bus.note_done !== 1'b0) begin bad++; $display("FAIL async_reset_no_done: got %0b want 0", bus.note_done); end
        @(negedge clk) reset = 1'b1;
        start_note(33, 1, 3);
        total++; if (bus.load_new_note !== 1'b1 || bus.cur_note !== 6'd33) begin
            bad++; $display("FAIL async_reset_restart: load=%0b cur=%0d want 1/33", bus.load_new_note, bus.cur_note); end
        step(); step();
        model_start(33, 1, 3);
        while (!m_fin && cyc < 50) begin
            bus.beat = (cyc == 7);
            step(); cyc++;
            model_edge(1'b1, bus.beat);
            total++; if (bus.tone !== model_tone() || bus.note_done !== m_fin) begin
                bad++; $display("FAIL async_reset_replay@%0d: tone=%0b done=%0b want %0b/%0b", cyc, bus.tone, bus.note_done, model_tone(), m_fin); end
        end
        bus.beat = 1'b0;
        total++; if (!m_fin) begin bad++; $display("FAIL async_reset_timeout: got %0d cycles want done", cyc); end
        step();
    endtask

    task automatic test_random();
        int n, d, hp, cyc;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 63); d = $urandom_range(0, 4); hp = $urandom_range(0, 6);
            bus.play = 1'b1;
            start_note(n, d, hp);
            if (d == 0) begin
                total++; if (bus.note_done !== 1'b1 || bus.load_new_note !== 1'b0) begin
                    bad++; $display("FAIL rand_zero[%0d]: done=%0b load=%0b want 1/0", k, bus.note_done, bus.load_new_note); end
                step();
                continue;
            end
            total++; if (bus.load_new_note !== 1'b1) begin bad++; $display("FAIL rand_load[%0d]: got %0b want 1", k, bus.load_new_note); end
            step(); step();
            model_start(n, d, hp);
            cyc = 0;
            while (!m_fin && cyc < 2000) begin
                bus.play     = ($urandom_range(0, 4) != 0);
                bus.beat     = ($urandom_range(0, 3) == 0);
                bus.new_note = ($urandom_range(0, 7) == 0);
                bus.note     = 6'($urandom);
                step(); cyc++;
                model_edge(bus.play, bus.beat);
                total++; if (bus.tone !== model_tone()) begin bad++; $display("FAIL rand_tone[%0d]@%0d: got %0b want %0b", k, cyc, bus.tone, model_tone()); end
                total++; if (bus.note_done !== m_fin) begin bad++; $display("FAIL rand_done[%0d]@%0d: got %0b want %0b", k, cyc, bus.note_done, m_fin); end
                total++; if (dut.remain !== BEAT_W'(m_left) || bus.cur_note !== 6'(n)) begin
                    bad++; $display("FAIL rand_state[%0d]@%0d: remain=%0d cur=%0d want %0d/%0d", k, cyc, dut.remain, bus.cur_note, m_left, n); end
            end
            bus.new_note = 1'b0; bus.beat = 1'b0; bus.play = 1'b1;
            total++; if (!m_fin) begin bad++; $display("FAIL rand_timeout[%0d]: got %0d cycles want done", k, cyc); end
            step();
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_idle[%0d]: busy got %0b want 0", k, bus.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_duration();
        test_rest();
        test_pause();
        test_pause_with_beat();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
